// File: rtl/breakpoint_unit.sv
// -----------------------------------------------------------------------------
// breakpoint_unit
//
// Responder side of the halt/breakpoint handshake with the clock controller.
// Holds NUM_BP programmable PC breakpoints, compares them against every
// qualified instruction fetch and drives the active-low hit line back to the
// controller, which gates the CPU clock while the hit is held.
//
// Optional feature (macro BREAKPOINT_MASK_EN):
//   defined   - each entry also stores a compare mask, so a breakpoint can
//               cover an address range ((pc & mask) == (addr & mask)).
//   undefined - no mask storage, i_bpMask is ignored, exact match only.
//
// Ports:
//   i_clk                system clock, rising edge
//   i_resetn             synchronous active-low reset
//   i_breakpointEnableN  0 = breakpoints armed, 1 = compare disabled
//   i_halt               1 = CPU clocked this cycle, 0 = CPU halted
//   i_fetch              instruction fetch strobe (valid with i_halt=1)
//   i_pc                 fetch address
//   i_bpWrite            write one breakpoint entry
//   i_bpIndex            entry index to write
//   i_bpAddr             breakpoint address
//   i_bpMask             compare mask (mask build only)
//   i_bpValid            valid bit written with the entry
//   i_bpClearAll         invalidate every entry (wins over i_bpWrite)
//   o_bpWriteAck         one-cycle pulse after an accepted write or clear
//   o_breakpointHitN     0 = breakpoint hit, halt requested
//   o_hitIndex           index of the most recent hit entry
//   o_hitCount           saturating count of hits since reset
//
// IDX_WIDTH must equal clog2(NUM_BP); NUM_BP is expected in 2..16.
// -----------------------------------------------------------------------------
module breakpoint_unit #(
  parameter int ADDR_WIDTH = 16,
  parameter int NUM_BP     = 4,
  parameter int IDX_WIDTH  = 2
) (
  input  logic                  i_clk,
  input  logic                  i_resetn,
  input  logic                  i_breakpointEnableN,
  input  logic                  i_halt,
  input  logic                  i_fetch,
  input  logic [ADDR_WIDTH-1:0] i_pc,
  input  logic                  i_bpWrite,
  input  logic [IDX_WIDTH-1:0]  i_bpIndex,
  input  logic [ADDR_WIDTH-1:0] i_bpAddr,
  input  logic [ADDR_WIDTH-1:0] i_bpMask,
  input  logic                  i_bpValid,
  input  logic                  i_bpClearAll,
  output logic                  o_bpWriteAck,
  output logic                  o_breakpointHitN,
  output logic [IDX_WIDTH-1:0]  o_hitIndex,
  output logic [7:0]            o_hitCount
);

  typedef enum logic [1:0] {
    ST_ARMED = 2'd0,
    ST_HIT   = 2'd1,
    ST_SKIP  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Breakpoint entry storage
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] bp_addr_q  [NUM_BP];
  logic [ADDR_WIDTH-1:0] bp_addr_d  [NUM_BP];
  logic [NUM_BP-1:0]     bp_valid_q;
  logic [NUM_BP-1:0]     bp_valid_d;
  logic                  write_ack_q;
  logic                  write_ack_d;

`ifdef BREAKPOINT_MASK_EN
  logic [ADDR_WIDTH-1:0] bp_mask_q  [NUM_BP];
  logic [ADDR_WIDTH-1:0] bp_mask_d  [NUM_BP];
`else
  // Mask input has no function in the exact-match build.
  logic unused_bp_mask;
  assign unused_bp_mask = ^i_bpMask;
`endif

  always_comb begin
    bp_addr_d   = bp_addr_q;
    bp_valid_d  = bp_valid_q;
    write_ack_d = 1'b0;
`ifdef BREAKPOINT_MASK_EN
    bp_mask_d   = bp_mask_q;
`endif
    if (i_bpClearAll) begin
      // Clear-all only drops valid bits; a simultaneous write is discarded.
      bp_valid_d  = '0;
      write_ack_d = 1'b1;
    end else if (i_bpWrite) begin
      write_ack_d = 1'b1;
      // Indices beyond NUM_BP (non power-of-two counts) are acknowledged
      // but have no storage behind them.
      if (int'(i_bpIndex) < NUM_BP) begin
        bp_addr_d[i_bpIndex]  = i_bpAddr;
        bp_valid_d[i_bpIndex] = i_bpValid;
`ifdef BREAKPOINT_MASK_EN
        bp_mask_d[i_bpIndex]  = i_bpMask;
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-entry compare (uses registered entries, so a same-cycle write does
  // not affect the current fetch)
  // ---------------------------------------------------------------------------
  logic [NUM_BP-1:0] match;

  for (genvar gi = 0; gi < NUM_BP; gi++) begin : g_match
`ifdef BREAKPOINT_MASK_EN
    assign match[gi] = bp_valid_q[gi] &
                       ((i_pc & bp_mask_q[gi]) == (bp_addr_q[gi] & bp_mask_q[gi]));
`else
    assign match[gi] = bp_valid_q[gi] & (i_pc == bp_addr_q[gi]);
`endif
  end

  // Lowest matching index wins: scan downward so the last assignment is the
  // smallest index.
  logic [IDX_WIDTH-1:0] winner;

  always_comb begin
    winner = '0;
    for (int k = NUM_BP - 1; k >= 0; k--) begin
      if (match[k]) begin
        winner = IDX_WIDTH'(k);
      end
    end
  end

  logic qual_fetch;
  assign qual_fetch = i_fetch & i_halt & ~i_breakpointEnableN;

  // ---------------------------------------------------------------------------
  // Handshake state machine
  // ---------------------------------------------------------------------------
  state_t                state_q,     state_d;
  logic                  hit_n_q,     hit_n_d;
  logic [IDX_WIDTH-1:0]  hit_index_q, hit_index_d;
  logic [7:0]            hit_count_q, hit_count_d;
  logic [ADDR_WIDTH-1:0] skip_addr_q, skip_addr_d;
  logic                  take_hit;

  always_comb begin
    state_d     = state_q;
    hit_n_d     = hit_n_q;
    hit_index_d = hit_index_q;
    hit_count_d = hit_count_q;
    skip_addr_d = skip_addr_q;
    take_hit    = 1'b0;

    case (state_q)
      ST_ARMED: begin
        if (qual_fetch && (|match)) begin
          take_hit = 1'b1;
        end
      end
      ST_HIT: begin
        // A sampled run cycle is a single-step release; disabling
        // breakpoints also releases the halt.
        if (i_halt || i_breakpointEnableN) begin
          state_d = ST_SKIP;
          hit_n_d = 1'b1;
        end
      end
      ST_SKIP: begin
        if (i_breakpointEnableN) begin
          state_d = ST_ARMED;
        end else if (qual_fetch) begin
          state_d = ST_ARMED;
          // Re-fetch of the instruction we stopped on must not re-trigger;
          // any other address is compared as usual.
          if ((i_pc != skip_addr_q) && (|match)) begin
            take_hit = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_ARMED;
        hit_n_d = 1'b1;
      end
    endcase

    if (take_hit) begin
      state_d     = ST_HIT;
      hit_n_d     = 1'b0;
      hit_index_d = winner;
      skip_addr_d = i_pc;
      hit_count_d = (hit_count_q == 8'hFF) ? hit_count_q : hit_count_q + 8'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      for (int k = 0; k < NUM_BP; k++) begin
        bp_addr_q[k] <= '0;
`ifdef BREAKPOINT_MASK_EN
        bp_mask_q[k] <= '0;
`endif
      end
      bp_valid_q  <= '0;
      write_ack_q <= 1'b0;
      state_q     <= ST_ARMED;
      hit_n_q     <= 1'b1;
      hit_index_q <= '0;
      hit_count_q <= '0;
      skip_addr_q <= '0;
    end else begin
      bp_addr_q   <= bp_addr_d;
`ifdef BREAKPOINT_MASK_EN
      bp_mask_q   <= bp_mask_d;
`endif
      bp_valid_q  <= bp_valid_d;
      write_ack_q <= write_ack_d;
      state_q     <= state_d;
      hit_n_q     <= hit_n_d;
      hit_index_q <= hit_index_d;
      hit_count_q <= hit_count_d;
      skip_addr_q <= skip_addr_d;
    end
  end

  assign o_bpWriteAck     = write_ack_q;
  assign o_breakpointHitN = hit_n_q;
  assign o_hitIndex       = hit_index_q;
  assign o_hitCount       = hit_count_q;

endmodule

// File: doc/breakpoint_unit.md
Name: breakpoint_unit

Overview:
- Responder side of the halt/breakpoint handshake with the clock controller.
- Consumes the controller's active-low breakpoint enable and run/halt line.
- Holds NUM_BP programmable PC breakpoints and compares them against each instruction fetch.
- Drives the active-low breakpoint-hit line back to the controller, which gates the CPU clock in run mode.

Parameters:
- ADDR_WIDTH, 16, width of PC and breakpoint addresses.
- NUM_BP, 4, number of breakpoint entries (2..16).
- IDX_WIDTH, 2, index width; must equal clog2(NUM_BP).

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_resetn  in  1  synchronous active-low reset.
- i_breakpointEnableN  in  1  0 = breakpoints armed; 1 = compare disabled.
- i_halt  in  1  controller run line: 1 = CPU clocked this cycle, 0 = CPU halted.
- i_fetch  in  1  strobe: new instruction fetch at i_pc; sampled only when i_halt=1.
- i_pc  in  ADDR_WIDTH  fetch address.
- i_bpWrite  in  1  write strobe for one breakpoint entry.
- i_bpIndex  in  IDX_WIDTH  entry to write.
- i_bpAddr  in  ADDR_WIDTH  breakpoint address.
- i_bpMask  in  ADDR_WIDTH  compare mask; used only with the optional feature.
- i_bpValid  in  1  entry valid bit written with the entry.
- i_bpClearAll  in  1  invalidate all entries.
- o_bpWriteAck  out  1  one-cycle pulse the cycle after an accepted write or clear.
- o_breakpointHitN  out  1  0 = breakpoint hit, halt requested.
- o_hitIndex  out  IDX_WIDTH  index of the last hit entry.
- o_hitCount  out  8  number of hits since reset, saturating.

Behaviour:
- Reset (i_resetn=0 at a clock edge):
  - All entries invalid; addr and mask cleared.
  - o_breakpointHitN=1, o_hitIndex=0, o_hitCount=0, o_bpWriteAck=0.
  - State ARMED; skip address cleared.
  - Reset wins over every other input, including in the middle of HIT.
- Entry writes:
  - When i_bpWrite=1, entry[i_bpIndex] takes {addr, mask, valid} at the clock edge.
  - i_bpClearAll=1 clears every valid bit; it has priority over a simultaneous i_bpWrite.
  - o_bpWriteAck pulses high for exactly 1 cycle, on the cycle after either action.
  - Writes are allowed in any state. A compare in the same cycle as a write uses the pre-write entry values.
- Match:
  - match[k] = valid[k] & (i_pc == addr[k]).
  - Qualified by i_fetch & i_halt & ~i_breakpointEnableN.
  - When several entries match, the lowest index wins.
- State machine:
  - ARMED:
    - On a qualified match, the next cycle has o_breakpointHitN=0, o_hitIndex=winner, skipAddr=i_pc, and o_hitCount increments (saturating at 255).
    - State goes to HIT. Latency from fetch to hit output is 1 cycle.
  - HIT:
    - o_breakpointHitN is held at 0.
    - Exit to SKIP when i_halt=1 is sampled (a step pulse) or i_breakpointEnableN=1.
    - o_breakpointHitN=1 from the cycle after the exit condition.
  - SKIP:
    - The first qualified fetch with i_pc==skipAddr is ignored (the resumed instruction), and the state returns to ARMED.
    - A qualified fetch at any other address returns to ARMED and is compared normally in that same cycle, so it may hit and go to HIT.
    - i_breakpointEnableN=1 in SKIP returns to ARMED.
- Disabled (i_breakpointEnableN=1): no new hits are raised; entries and counter are retained.
- Fetches with i_halt=0 are ignored in all states.
- o_hitIndex and o_hitCount hold their values until the next hit or reset.

Optional Feature:
- Macro: BREAKPOINT_MASK_EN.
- Defined:
  - Per-entry mask register is stored from i_bpMask.
  - match[k] = valid[k] & ((i_pc & mask[k]) == (addr[k] & mask[k])), allowing range breakpoints.
  - Mask all-ones gives an exact match. Mask 0 on a valid entry matches every fetch.
- Undefined:
  - No mask storage; i_bpMask is ignored; exact match only.

Test Plan:
- Write entry 1 = 0x0040 valid, enable=0, run with fetches 0x003E, 0x0040 -> o_bpWriteAck pulses once; o_breakpointHitN=0 exactly 1 cycle after the 0x0040 fetch; o_hitIndex=1; o_hitCount=1.
- Hold HIT with i_halt=0 for 10 cycles, then one i_halt=1 cycle with fetch 0x0040, then fetch 0x0042 -> hitN returns to 1; the 0x0040 re-fetch raises no hit; hitCount stays 1.
- Entries 0 and 2 both = 0x0100, fetch 0x0100 -> hit with o_hitIndex=0.
- i_breakpointEnableN=1 and fetch 0x0040 -> no hit. Assert i_resetn=0 during HIT -> hitN=1, hitCount=0; a subsequent fetch of 0x0040 does not hit (entries invalid).
- 300 hits alternating 0x0040/0x0050 with step-resume between -> hitCount saturates at 255. i_bpClearAll together with i_bpWrite -> all entries invalid, single ack.
- BREAKPOINT_MASK_EN: entry 0 addr=0x0200 mask=0xFF00, fetch 0x02A7 -> hit; without macro -> no hit.
